// File: rtl/demux1to3_stream.sv
// demux1to3_stream: registered 1-to-3 stream demultiplexer.
// One beat per cycle enters on a valid/ready input and is steered by in_sel
// (00=a, 01=b, 10=c) into a one-entry holding stage that drives the outputs.
// sel=11 is the unmapped code: by default the beat is accepted and dropped,
// and a saturating counter records how many were dropped.
// Optional feature macro: DEMUX_BCAST_EN -- when defined, sel=11 broadcasts
// the beat to all three outputs instead of dropping it.
module demux1to3_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_sel,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [DATA_WIDTH-1:0] c_data,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  busy
);

  localparam logic [1:0] SEL_UNMAPPED = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [2:0]             pend_q;       // pending outputs, bit order {c,b,a}
  logic [DATA_WIDTH-1:0]  hold_data_q;
  logic [CNT_WIDTH-1:0]   drop_cnt_q;

  logic [2:0]             ready_vec;
  logic [2:0]             pend_left;
  logic [2:0]             pend_d;
  logic                   drain;
  logic                   accept;
  logic                   load;
  logic                   drop;

  // Handshake decode: which pending outputs survive this cycle, and whether a new beat may enter.
  // in_ready depends combinationally on the x_ready inputs so a draining stage can refill
  // in the same cycle and sustain one beat per clock.
  always_comb begin
    ready_vec = {c_ready, b_ready, a_ready};
    pend_left = pend_q & ~ready_vec;
    busy      = (state_q == HOLD);
    drain     = busy & (pend_left == '0);
    in_ready  = ~busy | drain;
    accept    = in_valid & in_ready;
    load      = 1'b0;
    drop      = 1'b0;
    pend_d    = pend_left;
    if (accept) begin
      if (in_sel != SEL_UNMAPPED) begin
        load = 1'b1;
        unique case (in_sel)
          2'b00:   pend_d = 3'b001;
          2'b01:   pend_d = 3'b010;
          default: pend_d = 3'b100;
        endcase
      end else begin
`ifdef DEMUX_BCAST_EN
        load   = 1'b1;
        pend_d = '1;
`else
        // Accepting implies the stage is empty or draining, so pend_left is already zero.
        drop   = 1'b1;
`endif
      end
    end
  end

  // Holding-stage FSM: EMPTY/HOLD tracks whether any output bit is pending; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      pend_q      <= '0;
      hold_data_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      state_q <= (pend_d != '0) ? HOLD : EMPTY;
      if (load) begin
        hold_data_q <= in_data;
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Output mapping: every output shares the holding register; validity comes from its pending bit.
  always_comb begin
    a_valid  = pend_q[0];
    b_valid  = pend_q[1];
    c_valid  = pend_q[2];
    a_data   = hold_data_q;
    b_data   = hold_data_q;
    c_data   = hold_data_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_demux1to3_stream.sv
// Scoreboard bench for demux1to3_stream. Stimulus pushes nothing directly; a
// monitor on the falling edge observes accepted beats and pushes them into a
// per-output expected queue, then checks every output against those queues.
// Build with +define+DEMUX_BCAST_EN to exercise the broadcast variant.
module tb_demux1to3_stream;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          a_valid, b_valid, c_valid;
  logic          a_ready, b_ready, c_ready;
  logic [DW-1:0] a_data, b_data, c_data;
  logic [CW-1:0] drop_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO of outstanding beats per output, plus a drop tally.
  logic [DW-1:0] exp_q [0:2][$];
  int            drop_model = 0;

  demux1to3_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .c_data   (c_data),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the model, retire completed transfers, then record new accepts.
  logic [2:0]    m_vld, m_rdy;
  logic [DW-1:0] m_dat [0:2];
  logic          m_ir, m_any;
  always @(negedge clk) begin
    if (rst) begin
      for (int x = 0; x < 3; x++) exp_q[x].delete();
      drop_model = 0;
    end else begin
      m_vld = {c_valid, b_valid, a_valid};
      m_rdy = {c_ready, b_ready, a_ready};
      m_dat[0] = a_data;
      m_dat[1] = b_data;
      m_dat[2] = c_data;
      m_ir  = 1'b1;
      m_any = 1'b0;
      for (int x = 0; x < 3; x++) begin
        chk($sformatf("valid_%0d", x), 32'(m_vld[x]), 32'(exp_q[x].size() != 0));
        if (exp_q[x].size() != 0) begin
          m_any = 1'b1;
          chk($sformatf("data_%0d", x), 32'(m_dat[x]), 32'(exp_q[x][0]));
          if (!m_rdy[x]) m_ir = 1'b0;
        end
      end
      chk("busy", 32'(busy), 32'(m_any));
      chk("in_ready", 32'(in_ready), 32'(m_ir));
      chk("drop_cnt", 32'(drop_cnt), 32'(drop_model));
      for (int x = 0; x < 3; x++) begin
        if (m_vld[x] && m_rdy[x] && exp_q[x].size() != 0) void'(exp_q[x].pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel != 2'b11) begin
          exp_q[int'(in_sel)].push_back(in_data);
        end else begin
`ifdef DEMUX_BCAST_EN
          for (int x = 0; x < 3; x++) exp_q[x].push_back(in_data);
`else
          if (drop_model < DROP_MAX) drop_model++;
`endif
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] s;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_sel = '0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    c_ready = 1'b1;
    #1;
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_c_valid", 32'(c_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // T2: steer A5 to a, b, c in turn; visible one clock after accept.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sel = 2'(i);
      in_data = 8'hA5;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_valid", 32'({c_valid, b_valid, a_valid}), 32'(3'b001 << i));
      chk("t2_data", 32'(a_data), 32'h A5);
      cyc();
    end

    // T3: 16 back-to-back beats with all consumers ready.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_sel = 2'($urandom_range(0, 2));
      in_data = DW'($urandom);
      @(negedge clk);
      chk("t3_in_ready", 32'(in_ready), 1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();

    // T4: backpressure on b for 5 clocks, then a single transfer.
    b_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'b01;
    in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_b_valid", 32'(b_valid), 1);
      chk("t4_b_data", 32'(b_data), 32'h3C);
      chk("t4_in_ready", 32'(in_ready), 0);
      cyc();
    end
    b_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_valid", 32'(b_valid), 1);
    chk("t4_release_in_ready", 32'(in_ready), 1);
    cyc();
    @(negedge clk);
    chk("t4_after_valid", 32'(b_valid), 0);
    cyc();

    // Random traffic: all select codes, random readies and idle cycles.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel = 2'($urandom_range(0, 3));
      in_data = DW'($urandom);
      a_ready = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 3) != 0);
      c_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    c_ready = 1'b1;
    cyc();
    cyc();
    cyc();

`ifdef DEMUX_BCAST_EN
    // T6: broadcast with staggered consumer readiness.
    in_valid = 1'b1;
    in_sel = 2'b11;
    in_data = 8'h5A;
    b_ready = 1'b0;
    c_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      b_ready = (k >= 4);
      c_ready = (k >= 7);
      @(negedge clk);
      chk("t6_a_valid", 32'(a_valid), 32'(k == 1));
      chk("t6_b_valid", 32'(b_valid), 32'(k <= 4));
      chk("t6_c_valid", 32'(c_valid), 32'(k <= 7));
      chk("t6_in_ready", 32'(in_ready), 32'(k >= 7));
      chk("t6_drop_cnt", 32'(drop_cnt), 0);
      cyc();
    end
    @(negedge clk);
    chk("t6_busy_after", 32'(busy), 0);
    cyc();
`else
    // T5: 300 unmapped beats saturate the drop counter with no output activity.
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_sel = 2'b11;
      in_data = DW'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_drop_cnt", 32'(drop_cnt), DROP_MAX);
    chk("t5_no_valid", 32'({c_valid, b_valid, a_valid}), 0);
    cyc();
`endif

    // T1: asynchronous reset while a beat is held on a.
    a_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'b00;
    in_data = 8'h77;
    cyc();
    in_valid = 1'b0;
    #2;
    chk("t1_pre_a_valid", 32'(a_valid), 1);
    rst = 1'b1;
    #1;
    chk("t1_a_valid", 32'(a_valid), 0);
    chk("t1_b_valid", 32'(b_valid), 0);
    chk("t1_c_valid", 32'(c_valid), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_drop_cnt", 32'(drop_cnt), 0);
    cyc();
    rst = 1'b0;
    a_ready = 1'b1;
    cyc();
    s = 2'b10;
    in_valid = 1'b1;
    in_sel = s;
    in_data = 8'h11;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
